// File: rtl/aes_pkg.sv
// aes_pkg: shared AES-128 constants and helpers (S-box, Rcon, GF(2^8) xtime, byte positions).
package aes_pkg;

    typedef enum logic {IDLE, BUSY} state_e;

    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    // Indexed directly by the round number; entry 0 and the tail are unused padding.
    localparam logic [0:15][7:0] RCON = {
        8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
        8'h80, 8'h1b, 8'h36, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00
    };

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // MSB position of state byte (row r, column c); byte 0 sits in bits [127:120].
    function automatic int bpos(input int r, input int c);
        return 127 - 8 * (4 * c + r);
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// aes_sbox: combinational AES S-box lookup.
module aes_sbox
    import aes_pkg::*;
(
    input  logic [7:0] a_i,
    output logic [7:0] y_o
);
    assign y_o = SBOX[a_i];
endmodule

// File: rtl/aes_top.sv
// aes_top: iterative AES-128 encryption core, one round per clock, on-the-fly key expansion.
module aes_top
    import aes_pkg::*;
(
    input  logic         AES_clk,
    input  logic         AES_rst,
    input  logic         AES_en,
    input  logic [127:0] AES_data_in,
    input  logic [127:0] AES_key_in,
    output logic [127:0] AES_data_out,
    output logic         AES_data_out_valid
);
    state_e       fsm_q;
    logic [3:0]   rnd_q;
    logic [127:0] st_q, key_q, out_q, sb, sr, mc, rk_d, st_d;
    logic [31:0]  rot, sw, k0, k1, k2, k3;
    logic         vld_q;

    genvar i;
    for (i = 0; i < 16; i++) begin : g_sb
        aes_sbox u_sb (.a_i(st_q[127-8*i -: 8]), .y_o(sb[127-8*i -: 8]));
    end

    assign rot = {key_q[23:0], key_q[31:24]};
    for (i = 0; i < 4; i++) begin : g_kb
        aes_sbox u_kb (.a_i(rot[31-8*i -: 8]), .y_o(sw[31-8*i -: 8]));
    end

    assign k0   = key_q[127:96] ^ sw ^ {RCON[rnd_q], 24'h0};
    assign k1   = key_q[95:64] ^ k0;
    assign k2   = key_q[63:32] ^ k1;
    assign k3   = key_q[31:0] ^ k2;
    assign rk_d = {k0, k1, k2, k3};

    always_comb begin
        sr = '0;
        mc = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                sr[bpos(r, c) -: 8] = sb[bpos(r, (c + r) % 4) -: 8];
        // 2*a[r] ^ 3*a[r+1] ^ a[r+2] ^ a[r+3]
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                mc[bpos(r, c) -: 8] = xtime(sr[bpos(r, c) -: 8]) ^ xtime(sr[bpos((r + 1) % 4, c) -: 8])
                                    ^ sr[bpos((r + 1) % 4, c) -: 8] ^ sr[bpos((r + 2) % 4, c) -: 8]
                                    ^ sr[bpos((r + 3) % 4, c) -: 8];
    end

    assign st_d = ((rnd_q == 4'd10) ? sr : mc) ^ rk_d;

    always_ff @(posedge AES_clk) begin
        if (AES_rst) begin
            fsm_q <= IDLE;
            rnd_q <= '0;
            st_q  <= '0;
            key_q <= '0;
            out_q <= '0;
            vld_q <= 1'b0;
        end else begin
            vld_q <= 1'b0;
            if (fsm_q == IDLE) begin
                if (AES_en) begin
                    st_q  <= AES_data_in ^ AES_key_in;
                    key_q <= AES_key_in;
                    rnd_q <= 4'd1;
                    fsm_q <= BUSY;
                end
            end else begin
                st_q  <= st_d;
                key_q <= rk_d;
                rnd_q <= rnd_q + 4'd1;
                if (rnd_q == 4'd10) begin
                    out_q <= st_d;
                    vld_q <= 1'b1;
                    rnd_q <= '0;
                    fsm_q <= IDLE;
                end
            end
        end
    end

    assign AES_data_out       = out_q;
    assign AES_data_out_valid = vld_q;
endmodule

// File: tb/tb_aes_top.sv
// tb_aes_top: checks aes_top against a byte-array AES-128 model whose S-box is derived from GF(2^8) inversion.
module tb_aes_top;
    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         en = 1'b0;
    logic [127:0] din = '0, kin = '0;
    logic [127:0] out;
    logic         vld;
    int           checks = 0, errors = 0;

    localparam logic [127:0] KB = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] PB = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] CB = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] KC = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] PC = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CC = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] CZ = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

    aes_top dut (
        .AES_clk(clk), .AES_rst(rst), .AES_en(en), .AES_data_in(din), .AES_key_in(kin),
        .AES_data_out(out), .AES_data_out_valid(vld)
    );

    always #5 clk = ~clk;

    logic [7:0] sbt [256];

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        for (int k = 0; k < 8; k++) begin
            if (b[0]) p = p ^ a;
            a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        logic [7:0] r = b;
        for (int k = 0; k < n; k++) r = {r[6:0], r[7]};
        return r;
    endfunction

    task automatic build_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sbt[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [127:0] aes_enc(input logic [127:0] pt, input logic [127:0] key);
        logic [31:0]  w [44];
        logic [31:0]  tmp;
        logic [7:0]   s [16], t [16], a [4], rc;
        logic [127:0] res;
        rc = 8'h01;
        for (int k = 0; k < 4; k++) w[k] = key[127-32*k -: 32];
        for (int k = 4; k < 44; k++) begin
            tmp = w[k-1];
            if (k % 4 == 0) begin
                tmp = {tmp[23:0], tmp[31:24]};
                tmp = {sbt[tmp[31:24]], sbt[tmp[23:16]], sbt[tmp[15:8]], sbt[tmp[7:0]]} ^ {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end
            w[k] = w[k-4] ^ tmp;
        end
        for (int n = 0; n < 16; n++) s[n] = pt[127-8*n -: 8] ^ w[n/4][31-8*(n%4) -: 8];
        for (int r = 1; r <= 10; r++) begin
            for (int n = 0; n < 16; n++) s[n] = sbt[s[n]];
            for (int c = 0; c < 4; c++)
                for (int q = 0; q < 4; q++) t[4*c+q] = s[4*((c+q)%4)+q];
            for (int c = 0; c < 4; c++) begin
                for (int q = 0; q < 4; q++) a[q] = t[4*c+q];
                for (int q = 0; q < 4; q++)
                    s[4*c+q] = (r == 10) ? a[q] : gmul(8'h02, a[q]) ^ gmul(8'h03, a[(q+1)%4]) ^ a[(q+2)%4] ^ a[(q+3)%4];
            end
            for (int n = 0; n < 16; n++) s[n] = s[n] ^ w[4*r + n/4][31-8*(n%4) -: 8];
        end
        for (int n = 0; n < 16; n++) res[127-8*n -: 8] = s[n];
        return res;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Transaction-level timing model: capture when idle, result 10 edges later.
    int           busy = 0;
    logic [127:0] pend = '0, exp_out = '0;
    logic         exp_vld = 1'b0;

    always @(posedge clk) begin
        exp_vld = 1'b0;
        if (rst) begin
            busy = 0;
            exp_out = '0;
        end else if (busy > 0) begin
            busy--;
            if (busy == 0) begin
                exp_out = pend;
                exp_vld = 1'b1;
            end
        end else if (en) begin
            pend = aes_enc(din, kin);
            busy = 10;
        end
    end

    always @(negedge clk) begin
        chk("cyc valid", 128'(vld), 128'(exp_vld));
        chk("cyc data", out, exp_out);
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic run_vec(input string name, input logic [127:0] pt, input logic [127:0] k, input logic [127:0] exp);
        int n = 0;
        din = pt;
        kin = k;
        en = 1'b1;
        tick();
        en = 1'b0;
        while (!vld && n < 20) begin
            tick();
            n++;
        end
        chk({name, " latency"}, 128'(n), 128'd10);
        chk({name, " data"}, out, exp);
        tick();
        chk({name, " width"}, 128'(vld), 128'd0);
    endtask

    initial begin
        int n;
        build_sbox();
        chk("model sbox00", 128'(sbt[0]), 128'h63);
        chk("model sbox53", 128'(sbt[8'h53]), 128'hed);
        chk("model fipsB", aes_enc(PB, KB), CB);
        chk("model fipsC1", aes_enc(PC, KC), CC);
        chk("model zero", aes_enc('0, '0), CZ);

        repeat (2) tick();
        chk("reset data", out, 128'h0);
        chk("reset valid", 128'(vld), 128'd0);
        rst = 1'b0;
        tick();

        run_vec("fipsB", PB, KB, CB);
        run_vec("fipsC1", PC, KC, CC);
        run_vec("zero", '0, '0, CZ);

        din = PC; kin = KC; en = 1'b1;
        tick();
        en = 1'b0;
        repeat (4) tick();
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        chk("abort data", out, 128'h0);
        n = 0;
        repeat (15) begin
            tick();
            n += int'(vld);
        end
        chk("abort pulses", 128'(n), 128'd0);
        run_vec("after abort", PB, KB, CB);

        din = PB; kin = KB; en = 1'b1;
        n = 0;
        repeat (51) begin
            tick();
            n += int'(vld);
        end
        chk("hold pulses", 128'(n), 128'd4);
        en = 1'b0;
        repeat (15) tick();
        chk("hold data", out, CB);

        n = 0;
        repeat (20) begin
            din = {$urandom, $urandom, $urandom, $urandom};
            kin = {$urandom, $urandom, $urandom, $urandom};
            tick();
            n += int'(vld);
        end
        chk("idle pulses", 128'(n), 128'd0);
        chk("idle data", out, CB);

        repeat (400) begin
            din = {$urandom, $urandom, $urandom, $urandom};
            kin = {$urandom, $urandom, $urandom, $urandom};
            en  = ($urandom_range(0, 2) == 0);
            rst = ($urandom_range(0, 99) == 0);
            tick();
        end
        rst = 1'b0;
        en = 1'b0;
        repeat (15) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
